traffic_lights_multi: RTL and testbench
=======================================

// Module: traffic_lights_multi
// PURPOSE
//  Parametrised successor of the single-head traffic light controller: drives NUM_DIR
//  signal heads (red/yellow/green each) of one intersection, granting right-of-way to
//  one direction at a time in round-robin order. Per-direction green times, shared
//  yellow and all-red clearance times. Adds a "shorten green" request command.
//  Sits between the command bus (cmd_*_i) and the lamp drivers.
// PARAMETERS
//  NUM_DIR          2     number of directions/heads (2..8)
//  TIME_W           16    width of cmd_data_i and time registers (ms)
//  TICKS_PER_MS     2     clk cycles per ms (2 kHz clock)
//  BLINK_HALF_MS    250   half-period of any blinking, ms
//  GREEN_BLINKS     3     green blink periods before yellow
//  RED_YELLOW_MS    100   red+yellow overlap before green, ms
//  DEF_GREEN_MS     1000  reset value of every green time
//  DEF_YELLOW_MS    300   reset value of yellow time
//  DEF_RED_MS       500   reset value of all-red clearance time
// PORTS
//  clk_i         in   1              clock
//  srst_i        in   1              synchronous reset, active-high
//  cmd_type_i    in   3              command code (see BEHAVIOUR)
//  cmd_valid_i   in   1              command strobe, one command per cycle
//  cmd_data_i    in   TIME_W         time value in ms for set commands
//  cmd_dir_i     in   DIR_W          target direction for SET_GREEN; DIR_W=max(1,$clog2(NUM_DIR))
//  red_o         out  NUM_DIR        red lamp per direction
//  yellow_o      out  NUM_DIR        yellow lamp per direction
//  green_o       out  NUM_DIR        green lamp per direction
//  active_dir_o  out  DIR_W          direction owning current phase sequence
// BEHAVIOUR
//  - Modes: RUN, OFF, UNMANAGED. Commands: 0 ON, 1 OFF, 2 UNMANAGED, 3 SET_GREEN[cmd_dir_i],
//    4 SET_RED, 5 SET_YELLOW, 6 SHORTEN, 7 reserved (ignored). Sampled only when cmd_valid_i.
//  - All outputs registered; a command sampled at edge k is visible on outputs after edge k+1.
//  - Reset: mode RUN, phase ALL_RED, active_dir_o=NUM_DIR-1 (so dir 0 is served first),
//    red_o all ones, yellow_o=green_o=0; timers reloaded; green/yellow/red times = DEF_*.
//  - RUN phase FSM for active dir d (all other dirs red only):
//    ALL_RED (red_ms, all heads red) -> advance d=(d+1)%NUM_DIR -> RED_YELLOW (RED_YELLOW_MS,
//    red+yellow on d) -> GREEN (green_ms[d]) -> GREEN_BLINK (2*GREEN_BLINKS half-periods,
//    green on during first half of each) -> YELLOW (yellow_ms) -> ALL_RED.
//  - Phase duration in cycles = ms*TICKS_PER_MS exactly; counter width
//    TIME_W+$clog2(TICKS_PER_MS+1), no truncation. Time value 0 is stored as 1.
//  - ON: from OFF/UNMANAGED enter ALL_RED with timer reloaded, active_dir_o unchanged;
//    ignored when already RUN (no restart).
//  - OFF: all lamps 0, FSM held. UNMANAGED: all yellow_o blink together, on for the first
//    BLINK_HALF_MS after entry, red/green 0. Re-issuing current mode command: no effect.
//  - SET_GREEN/RED/YELLOW: accepted only in OFF or UNMANAGED; ignored in RUN. SET_GREEN with
//    cmd_dir_i>=NUM_DIR ignored. New values take effect from next phase load.
//  - SHORTEN: in RUN+GREEN, remaining green time truncated: GREEN_BLINK starts next cycle.
//    In any other phase/mode ignored (not queued).
//  - Invariant: at most one direction shows green or yellow in RUN; in every state each
//    head has exactly the lamps defined above, never green and red together.
//  - srst_i overrides any simultaneous command; mid-operation reset returns to reset state.
// STRUCTURE
//  - Package traffic_lights_pkg: cmd_type_t enum (ON..SHORTEN), mode_t, phase_t, DEF_* widths.
//  - Sub-module tl_ms_timer: loadable down-counter (load ms, prescale by TICKS_PER_MS,
//    done pulse), instantiated once for phases and once for blink half-periods.
// TESTING (bench uses TICKS_PER_MS=2, BLINK_HALF_MS=2, GREEN_BLINKS=2, NUM_DIR=3)
//  - Reset, no cmds -> red_o=3'b111 for DEF_RED_MS*2 cycles, then dir0 red+yellow 200 cycles,
//    green 2000 cycles, blinks 4x4 cycles, yellow 600 cycles; dirs 1,2 red throughout.
//  - OFF; SET_GREEN dir1=5, SET_RED=3, SET_YELLOW=4; ON -> all-red 6 cycles, dir1 green
//    10 cycles, yellow 8 cycles; dir0/2 greens keep defaults.
//  - SET_GREEN in RUN -> ignored, timing unchanged; cmd 7 and cmd_dir_i=3 -> ignored.
//  - UNMANAGED -> all yellow on 4 cycles/off 4 cycles, red/green 0; ON -> all-red restart.
//  - SHORTEN mid-GREEN -> GREEN_BLINK from next cycle; SHORTEN in YELLOW -> no effect.
//  - srst_i asserted with cmd_valid_i ON during UNMANAGED -> reset state next cycle.
//  - Assertion every cycle: per head !(red&&green); in RUN popcount(green_o|yellow_o
//    excluding RED_YELLOW)<=1.

Source files
------------

// File: rtl/traffic_lights_pkg.sv
// Shared types and defaults for the multi-head traffic light controller.
//  - cmd_type_t : command codes on cmd_type_i
//  - mode_t     : top-level operating mode (RUN / OFF / UNMANAGED)
//  - phase_t    : right-of-way phase sequence used while in RUN
//  - DEF_*      : default time values (ms) used as module parameter defaults
//  - ms_floor1  : maps a time value of 0 ms onto 1 ms
package traffic_lights_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_ON         = 3'd0,
        CMD_OFF        = 3'd1,
        CMD_UNMANAGED  = 3'd2,
        CMD_SET_GREEN  = 3'd3,
        CMD_SET_RED    = 3'd4,
        CMD_SET_YELLOW = 3'd5,
        CMD_SHORTEN    = 3'd6,
        CMD_RESERVED   = 3'd7
    } cmd_type_t;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_OFF       = 2'd1,
        MODE_UNMANAGED = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        PH_ALL_RED     = 3'd0,
        PH_RED_YELLOW  = 3'd1,
        PH_GREEN       = 3'd2,
        PH_GREEN_BLINK = 3'd3,
        PH_YELLOW      = 3'd4
    } phase_t;

    localparam int DEF_TIME_W        = 16;
    localparam int DEF_GREEN_MS_VAL  = 1000;
    localparam int DEF_YELLOW_MS_VAL = 300;
    localparam int DEF_RED_MS_VAL    = 500;

    // A stored time of 0 ms would give a zero-length phase; treat it as 1 ms.
    function automatic int ms_floor1(input int ms);
        return (ms < 1) ? 1 : ms;
    endfunction

endpackage

// File: rtl/tl_ms_timer.sv
// Loadable millisecond down-counter.
// The load value (ms) is converted to clock cycles (ms * TICKS_PER_MS) and
// counted down; done_o is high during the last cycle of the loaded interval,
// so a consumer that reloads on done_o gets intervals of exactly
// ms * TICKS_PER_MS cycles. Without a reload the counter parks at 0.
// Ports:
//  clk_i   in  1       clock
//  srst_i  in  1       synchronous reset, active-high (loads RST_MS)
//  load_i  in  1       restart the interval with ms_i
//  ms_i    in  TIME_W  interval length in ms (0 is treated as 1)
//  done_o  out 1       last cycle of the current interval
module tl_ms_timer
    import traffic_lights_pkg::*;
#(
    parameter int TIME_W       = 16,
    parameter int TICKS_PER_MS = 2,
    parameter int RST_MS       = 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              load_i,
    input  logic [TIME_W-1:0] ms_i,
    output logic              done_o
);

    // Wide enough for the full ms range times the prescale, no truncation.
    localparam int CNT_W = TIME_W + $clog2(TICKS_PER_MS + 1);
    localparam logic [CNT_W-1:0] RST_CYCLES = CNT_W'(ms_floor1(RST_MS) * TICKS_PER_MS);

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [TIME_W-1:0] ms_eff;
    logic [CNT_W-1:0]  load_cycles;

    always_comb begin
        ms_eff      = (ms_i == '0) ? TIME_W'(1) : ms_i;
        load_cycles = CNT_W'(ms_eff) * CNT_W'(TICKS_PER_MS);
        cnt_d       = cnt_q;
        if (load_i) begin
            cnt_d = load_cycles;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= RST_CYCLES;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_lights_multi.sv
// Multi-head traffic light controller for one intersection.
// NUM_DIR heads get right-of-way one at a time in round-robin order:
//   ALL_RED -> (advance dir) -> RED_YELLOW -> GREEN -> GREEN_BLINK -> YELLOW -> ALL_RED
// Modes RUN / OFF / UNMANAGED are selected over the command bus; time
// settings may only be changed while not in RUN.
// Command bus handshake: cmd_valid_i is a single-cycle strobe with no
// back-pressure (there is no ready); every cycle with cmd_valid_i high
// delivers exactly one command, captured into a register stage and acted
// on at the following edge, so outputs react one edge after capture.
// Ports:
//  clk_i         in   1        clock
//  srst_i        in   1        synchronous reset, active-high (beats any command)
//  cmd_type_i    in   3        command code (cmd_type_t)
//  cmd_valid_i   in   1        command strobe
//  cmd_data_i    in   TIME_W   time value in ms for SET_* commands
//  cmd_dir_i     in   DIR_W    target direction for SET_GREEN
//  red_o         out  NUM_DIR  red lamp per head
//  yellow_o      out  NUM_DIR  yellow lamp per head
//  green_o       out  NUM_DIR  green lamp per head
//  active_dir_o  out  DIR_W    direction owning the current phase sequence
module traffic_lights_multi
    import traffic_lights_pkg::*;
#(
    parameter int NUM_DIR       = 2,
    parameter int TIME_W        = DEF_TIME_W,
    parameter int TICKS_PER_MS  = 2,
    parameter int BLINK_HALF_MS = 250,
    parameter int GREEN_BLINKS  = 3,
    parameter int RED_YELLOW_MS = 100,
    parameter int DEF_GREEN_MS  = DEF_GREEN_MS_VAL,
    parameter int DEF_YELLOW_MS = DEF_YELLOW_MS_VAL,
    parameter int DEF_RED_MS    = DEF_RED_MS_VAL,
    localparam int DIR_W        = (NUM_DIR > 2) ? $clog2(NUM_DIR) : 1
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [2:0]         cmd_type_i,
    input  logic               cmd_valid_i,
    input  logic [TIME_W-1:0]  cmd_data_i,
    input  logic [DIR_W-1:0]   cmd_dir_i,
    output logic [NUM_DIR-1:0] red_o,
    output logic [NUM_DIR-1:0] yellow_o,
    output logic [NUM_DIR-1:0] green_o,
    output logic [DIR_W-1:0]   active_dir_o
);

    localparam int HC_W = (GREEN_BLINKS > 1) ? $clog2(2 * GREEN_BLINKS) : 1;
    localparam logic [HC_W-1:0]   HALF_LAST  = HC_W'(2 * GREEN_BLINKS - 1);
    localparam logic [TIME_W-1:0] GREEN_RST  = TIME_W'(ms_floor1(DEF_GREEN_MS));
    localparam logic [TIME_W-1:0] YELLOW_RST = TIME_W'(ms_floor1(DEF_YELLOW_MS));
    localparam logic [TIME_W-1:0] RED_RST    = TIME_W'(ms_floor1(DEF_RED_MS));
    localparam logic [TIME_W-1:0] RY_MS      = TIME_W'(ms_floor1(RED_YELLOW_MS));
    localparam logic [TIME_W-1:0] BLINK_MS   = TIME_W'(ms_floor1(BLINK_HALF_MS));
    localparam logic [DIR_W-1:0]  LAST_DIR   = DIR_W'(NUM_DIR - 1);

    // Command capture stage
    logic              cmd_vld_q,  cmd_vld_d;
    cmd_type_t         cmd_type_q, cmd_type_d;
    logic [TIME_W-1:0] cmd_data_q, cmd_data_d;
    logic [DIR_W-1:0]  cmd_dir_q,  cmd_dir_d;

    // Controller state
    mode_t             mode_q,     mode_d;
    phase_t            phase_q,    phase_d;
    logic [DIR_W-1:0]  dir_q,      dir_d;
    logic [HC_W-1:0]   half_q,     half_d;
    logic              blink_on_q, blink_on_d;
    logic [TIME_W-1:0] green_ms_q [NUM_DIR];
    logic [TIME_W-1:0] green_ms_d [NUM_DIR];
    logic [TIME_W-1:0] yellow_ms_q, yellow_ms_d;
    logic [TIME_W-1:0] red_ms_q,    red_ms_d;

    // Registered lamp outputs
    logic [NUM_DIR-1:0] red_q,    red_d;
    logic [NUM_DIR-1:0] yellow_q, yellow_d;
    logic [NUM_DIR-1:0] green_q,  green_d;

    // Timer control
    logic              ph_load, ph_done;
    logic [TIME_W-1:0] ph_ms;
    logic              bl_load, bl_done;

    logic              run_hold;
    logic              shorten;
    logic              cfg_ok;
    logic [TIME_W-1:0] cmd_ms;

    tl_ms_timer #(
        .TIME_W       (TIME_W),
        .TICKS_PER_MS (TICKS_PER_MS),
        .RST_MS       (DEF_RED_MS)
    ) u_phase_timer (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .load_i (ph_load),
        .ms_i   (ph_ms),
        .done_o (ph_done)
    );

    tl_ms_timer #(
        .TIME_W       (TIME_W),
        .TICKS_PER_MS (TICKS_PER_MS),
        .RST_MS       (BLINK_HALF_MS)
    ) u_blink_timer (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .load_i (bl_load),
        .ms_i   (BLINK_MS),
        .done_o (bl_done)
    );

    always_comb begin
        cmd_vld_d  = cmd_valid_i;
        cmd_type_d = cmd_type_t'(cmd_type_i);
        cmd_data_d = cmd_data_i;
        cmd_dir_d  = cmd_dir_i;

        mode_d      = mode_q;
        phase_d     = phase_q;
        dir_d       = dir_q;
        half_d      = half_q;
        blink_on_d  = blink_on_q;
        green_ms_d  = green_ms_q;
        yellow_ms_d = yellow_ms_q;
        red_ms_d    = red_ms_q;

        ph_load = 1'b0;
        ph_ms   = red_ms_q;
        bl_load = 1'b0;

        cfg_ok  = (mode_q != MODE_RUN);
        cmd_ms  = (cmd_data_q == '0) ? TIME_W'(1) : cmd_data_q;
        shorten = cmd_vld_q && (cmd_type_q == CMD_SHORTEN);

        // Mode and configuration commands
        if (cmd_vld_q) begin
            case (cmd_type_q)
                CMD_ON: begin
                    // Restart from a clean all-red; the active direction is kept
                    // so service resumes with the next head in turn.
                    if (mode_q != MODE_RUN) begin
                        mode_d  = MODE_RUN;
                        phase_d = PH_ALL_RED;
                        ph_load = 1'b1;
                        ph_ms   = red_ms_q;
                    end
                end
                CMD_OFF: begin
                    mode_d = MODE_OFF;
                end
                CMD_UNMANAGED: begin
                    if (mode_q != MODE_UNMANAGED) begin
                        mode_d     = MODE_UNMANAGED;
                        blink_on_d = 1'b1;
                        bl_load    = 1'b1;
                    end
                end
                CMD_SET_GREEN: begin
                    if (cfg_ok && (int'(cmd_dir_q) < NUM_DIR)) begin
                        green_ms_d[cmd_dir_q] = cmd_ms;
                    end
                end
                CMD_SET_RED: begin
                    if (cfg_ok) begin
                        red_ms_d = cmd_ms;
                    end
                end
                CMD_SET_YELLOW: begin
                    if (cfg_ok) begin
                        yellow_ms_d = cmd_ms;
                    end
                end
                default: ;
            endcase
        end

        // Phase sequencing only runs when RUN is neither entered nor left this cycle.
        run_hold = (mode_q == MODE_RUN) && (mode_d == MODE_RUN);
        if (run_hold) begin
            case (phase_q)
                PH_ALL_RED: begin
                    if (ph_done) begin
                        dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
                        phase_d = PH_RED_YELLOW;
                        ph_load = 1'b1;
                        ph_ms   = RY_MS;
                    end
                end
                PH_RED_YELLOW: begin
                    if (ph_done) begin
                        phase_d = PH_GREEN;
                        ph_load = 1'b1;
                        ph_ms   = green_ms_q[dir_q];
                    end
                end
                PH_GREEN: begin
                    if (ph_done || shorten) begin
                        phase_d = PH_GREEN_BLINK;
                        half_d  = '0;
                        bl_load = 1'b1;
                    end
                end
                PH_GREEN_BLINK: begin
                    // Even half-periods show green, odd ones are dark.
                    if (bl_done) begin
                        if (half_q == HALF_LAST) begin
                            phase_d = PH_YELLOW;
                            ph_load = 1'b1;
                            ph_ms   = yellow_ms_q;
                        end else begin
                            half_d  = half_q + 1'b1;
                            bl_load = 1'b1;
                        end
                    end
                end
                PH_YELLOW: begin
                    if (ph_done) begin
                        phase_d = PH_ALL_RED;
                        ph_load = 1'b1;
                        ph_ms   = red_ms_q;
                    end
                end
                default: begin
                    phase_d = PH_ALL_RED;
                    ph_load = 1'b1;
                    ph_ms   = red_ms_q;
                end
            endcase
        end

        // Unmanaged flashing: toggle all yellows every half-period.
        if ((mode_q == MODE_UNMANAGED) && (mode_d == MODE_UNMANAGED) && bl_done) begin
            blink_on_d = ~blink_on_q;
            bl_load    = 1'b1;
        end

        // Lamps are decoded from next-state so they register alongside the state.
        red_d    = '0;
        yellow_d = '0;
        green_d  = '0;
        case (mode_d)
            MODE_RUN: begin
                red_d = '1;
                case (phase_d)
                    PH_RED_YELLOW: begin
                        yellow_d[dir_d] = 1'b1;
                    end
                    PH_GREEN: begin
                        red_d[dir_d]   = 1'b0;
                        green_d[dir_d] = 1'b1;
                    end
                    PH_GREEN_BLINK: begin
                        red_d[dir_d]   = 1'b0;
                        green_d[dir_d] = ~half_d[0];
                    end
                    PH_YELLOW: begin
                        red_d[dir_d]    = 1'b0;
                        yellow_d[dir_d] = 1'b1;
                    end
                    default: ;
                endcase
            end
            MODE_UNMANAGED: begin
                yellow_d = {NUM_DIR{blink_on_d}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cmd_vld_q   <= 1'b0;
            cmd_type_q  <= CMD_RESERVED;
            cmd_data_q  <= '0;
            cmd_dir_q   <= '0;
            mode_q      <= MODE_RUN;
            phase_q     <= PH_ALL_RED;
            dir_q       <= LAST_DIR;
            half_q      <= '0;
            blink_on_q  <= 1'b0;
            for (int i = 0; i < NUM_DIR; i++) begin
                green_ms_q[i] <= GREEN_RST;
            end
            yellow_ms_q <= YELLOW_RST;
            red_ms_q    <= RED_RST;
            red_q       <= '1;
            yellow_q    <= '0;
            green_q     <= '0;
        end else begin
            cmd_vld_q   <= cmd_vld_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            cmd_dir_q   <= cmd_dir_d;
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            blink_on_q  <= blink_on_d;
            green_ms_q  <= green_ms_d;
            yellow_ms_q <= yellow_ms_d;
            red_ms_q    <= red_ms_d;
            red_q       <= red_d;
            yellow_q    <= yellow_d;
            green_q     <= green_d;
        end
    end

    assign red_o        = red_q;
    assign yellow_o     = yellow_q;
    assign green_o      = green_q;
    assign active_dir_o = dir_q;

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Directed bench for traffic_lights_multi with NUM_DIR=3, TICKS_PER_MS=2,
// BLINK_HALF_MS=2, GREEN_BLINKS=2 and default times.
// Inputs are driven and outputs sampled on the falling clock edge.
// Command latency: a command driven before rising edge k is captured at k
// and shows on the lamps after rising edge k+1.
module tb_traffic_lights_multi;

    localparam int NUM_DIR = 3;
    localparam int TIME_W  = 16;
    localparam int DIR_W   = 2;

    // Expected lamp patterns (d = direction concerned)
    localparam int AR   = 0;  // all red
    localparam int RY   = 1;  // red+yellow on d
    localparam int GR   = 2;  // green on d
    localparam int BOFF = 3;  // blink dark half on d
    localparam int YE   = 4;  // yellow on d
    localparam int DARK = 5;  // everything off
    localparam int UY   = 6;  // unmanaged, all yellow on

    localparam logic [2:0] C_ON    = 3'd0;
    localparam logic [2:0] C_OFF   = 3'd1;
    localparam logic [2:0] C_UNM   = 3'd2;
    localparam logic [2:0] C_SETG  = 3'd3;
    localparam logic [2:0] C_SETR  = 3'd4;
    localparam logic [2:0] C_SETY  = 3'd5;
    localparam logic [2:0] C_SHORT = 3'd6;
    localparam logic [2:0] C_RSV   = 3'd7;

    logic               clk = 1'b0;
    logic               srst_i;
    logic [2:0]         cmd_type_i;
    logic               cmd_valid_i;
    logic [TIME_W-1:0]  cmd_data_i;
    logic [DIR_W-1:0]   cmd_dir_i;
    logic [NUM_DIR-1:0] red_o;
    logic [NUM_DIR-1:0] yellow_o;
    logic [NUM_DIR-1:0] green_o;
    logic [DIR_W-1:0]   active_dir_o;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    traffic_lights_multi #(
        .NUM_DIR       (NUM_DIR),
        .TIME_W        (TIME_W),
        .TICKS_PER_MS  (2),
        .BLINK_HALF_MS (2),
        .GREEN_BLINKS  (2),
        .RED_YELLOW_MS (100),
        .DEF_GREEN_MS  (1000),
        .DEF_YELLOW_MS (300),
        .DEF_RED_MS    (500)
    ) dut (
        .clk_i        (clk),
        .srst_i       (srst_i),
        .cmd_type_i   (cmd_type_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_dir_i    (cmd_dir_i),
        .red_o        (red_o),
        .yellow_o     (yellow_o),
        .green_o      (green_o),
        .active_dir_o (active_dir_o)
    );

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [2:0] t, input logic [TIME_W-1:0] data,
                        input logic [DIR_W-1:0] dir);
        cmd_type_i  = t;
        cmd_data_i  = data;
        cmd_dir_i   = dir;
        cmd_valid_i = 1'b1;
        tick(1);
        cmd_valid_i = 1'b0;
    endtask

    // ---------------- model / scoreboard ----------------
    function automatic logic [10:0] expected(input int ph, input int d, input int adir);
        logic [2:0] b;
        logic [2:0] r;
        logic [2:0] y;
        logic [2:0] g;
        b = 3'b001 << d;
        r = 3'b000;
        y = 3'b000;
        g = 3'b000;
        case (ph)
            AR:   r = 3'b111;
            RY:   begin r = 3'b111; y = b; end
            GR:   begin r = ~b; g = b; end
            BOFF: r = ~b;
            YE:   begin r = ~b; y = b; end
            UY:   y = 3'b111;
            default: ;
        endcase
        return {r, y, g, 2'(adir)};
    endfunction

    // Check the lamps and active direction for len consecutive cycles.
    task automatic seg(input string tag, input int ph, input int d, input int adir,
                       input int len);
        logic [10:0] obs;
        logic [10:0] exp_v;
        exp_v = expected(ph, d, adir);
        for (int i = 0; i < len; i++) begin
            obs = {red_o, yellow_o, green_o, active_dir_o};
            checks++;
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s cycle %0d: observed r_y_g_dir=%b required %b", tag, i, obs, exp_v);
            end
            tick(1);
        end
    endtask

    task automatic blink(input string tag, input int d);
        seg({tag, "_on0"},  GR,   d, d, 4);
        seg({tag, "_off0"}, BOFF, d, d, 4);
        seg({tag, "_on1"},  GR,   d, d, 4);
        seg({tag, "_off1"}, BOFF, d, d, 4);
    endtask

    // Lamp invariants on every cycle outside reset.
    always @(negedge clk) begin
        if (!srst_i) begin
            checks++;
            assert ((red_o & green_o) === 3'b000) else begin
                errors++;
                $error("FAIL inv_red_green: observed red=%b green=%b required no overlap", red_o, green_o);
            end
            if (red_o != 3'b000) begin
                checks++;
                assert ($countones((green_o | yellow_o) & ~(red_o & yellow_o)) <= 1) else begin
                    errors++;
                    $error("FAIL inv_one_dir: observed g=%b y=%b r=%b required <=1 active head",
                           green_o, yellow_o, red_o);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        srst_i      = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_type_i  = 3'd0;
        cmd_data_i  = '0;
        cmd_dir_i   = '0;
        tick(3);
        srst_i = 1'b0;

        // Default cycle, no commands
        seg("t1_allred", AR, 0, 2, 1000);
        seg("t1_ry0",    RY, 0, 0, 200);
        seg("t1_gr0",    GR, 0, 0, 2000);
        blink("t1_bk0", 0);
        seg("t1_ye0",    YE, 0, 0, 600);
        seg("t1_ar0",    AR, 0, 0, 10);

        // OFF, then reconfigure (including commands that must be ignored)
        send(C_OFF, 16'd0, 2'd0);
        seg("t2_off_lat", AR, 0, 0, 1);
        seg("t2_dark",  DARK, 0, 0, 3);
        send(C_SETG, 16'd5, 2'd1);
        send(C_SETR, 16'd3, 2'd0);
        send(C_SETY, 16'd4, 2'd0);
        send(C_SETG, 16'd7, 2'd3);
        send(C_RSV,  16'd1, 2'd0);
        send(C_SHORT, 16'd0, 2'd0);
        seg("t2_dark_cfg", DARK, 0, 0, 2);
        send(C_ON, 16'd0, 2'd0);
        seg("t2_on_lat", DARK, 0, 0, 1);
        seg("t2_ar",  AR, 0, 0, 6);
        seg("t2_ry1", RY, 1, 1, 100);

        // Settings and ON while running must be ignored
        send(C_SETG, 16'd1, 2'd2);
        send(C_RSV,  16'd1, 2'd0);
        send(C_SETR, 16'd1, 2'd0);
        send(C_ON,   16'd0, 2'd0);
        seg("t3_ry1",  RY, 1, 1, 96);
        seg("t2_gr1",  GR, 1, 1, 10);
        blink("t2_bk1", 1);
        seg("t2_ye1",  YE, 1, 1, 8);
        seg("t3_ar1",  AR, 0, 1, 6);
        seg("t3_ry2",  RY, 2, 2, 200);
        seg("t3_gr2",  GR, 2, 2, 2000);
        blink("t3_bk2", 2);
        seg("t2_ye2",  YE, 2, 2, 8);
        seg("t2_ar2",  AR, 0, 2, 6);
        seg("t2_ry0",  RY, 0, 0, 200);

        // SHORTEN during green, then during yellow
        seg("t5_gr0",  GR, 0, 0, 500);
        send(C_SHORT, 16'd0, 2'd0);
        seg("t5_gr0_lat", GR, 0, 0, 1);
        blink("t5_bk0", 0);
        seg("t5_ye0a", YE, 0, 0, 3);
        send(C_SHORT, 16'd0, 2'd0);
        seg("t5_ye0b", YE, 0, 0, 4);
        seg("t5_ar0",  AR, 0, 0, 3);

        // Unmanaged flashing; re-issuing UNMANAGED must not restart it
        send(C_UNM, 16'd0, 2'd0);
        seg("t4_unm_lat", AR, 0, 0, 1);
        seg("t4_on0",   UY,   0, 0, 4);
        send(C_UNM, 16'd0, 2'd0);
        seg("t4_off0",  DARK, 0, 0, 3);
        seg("t4_on1",   UY,   0, 0, 4);
        seg("t4_off1",  DARK, 0, 0, 4);
        seg("t4_on2a",  UY,   0, 0, 1);
        send(C_ON, 16'd0, 2'd0);
        seg("t4_on2b",  UY,   0, 0, 1);
        seg("t4_ar",    AR,   0, 0, 6);
        seg("t4_ry1",   RY,   1, 1, 5);

        // Reset together with an ON command while unmanaged
        send(C_UNM, 16'd0, 2'd0);
        seg("t6_ry1_lat", RY, 1, 1, 1);
        seg("t6_unm",     UY, 0, 1, 2);
        srst_i      = 1'b1;
        cmd_type_i  = C_ON;
        cmd_valid_i = 1'b1;
        tick(1);
        srst_i      = 1'b0;
        cmd_valid_i = 1'b0;
        seg("t6_rst_ar", AR, 0, 2, 1000);
        seg("t6_rst_ry0", RY, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
